// File: rtl/ether_pkg.sv
// ---------------------------------------------------------------------------
// ether_pkg
// Shared types and constants for the link-aware TX stream gate.
//   link_state_t  : debounced link FSM states
//   frame_state_t : per-frame forwarding decision states
//   LINK_UP_CYCLES_DEFAULT : default healthy-cycle count before link is up
// ---------------------------------------------------------------------------
package ether_pkg;

   typedef enum logic [1:0] {
      DOWN   = 2'd0,
      SETTLE = 2'd1,
      UP     = 2'd2
   } link_state_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PASS = 2'd1,
      DROP = 2'd2
   } frame_state_t;

   localparam int unsigned LINK_UP_CYCLES_DEFAULT = 1024;

endpackage

// File: rtl/axis_skid_buf.sv
// ---------------------------------------------------------------------------
// axis_skid_buf
// Two-entry AXI4-Stream register slice. The output register gives one cycle
// of latency; the skid register catches the beat already in flight when the
// sink stops accepting, so s_ready can be a plain flop output.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_data/s_valid/s_ready  upstream side, WIDTH-bit opaque payload
//   m_data/m_valid/m_ready  downstream side
// ---------------------------------------------------------------------------
module axis_skid_buf #(
   parameter int unsigned WIDTH = 74
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready
);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic             skid_valid_q, skid_valid_d;
   logic [WIDTH-1:0] skid_data_q,  skid_data_d;
   logic             s_fire;

   assign s_ready = ~skid_valid_q;
   assign m_valid = out_valid_q;
   assign m_data  = out_data_q;
   assign s_fire  = s_valid & ~skid_valid_q;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (m_ready | ~out_valid_q) begin
         // Output register is free this cycle: refill from skid first to
         // keep order, otherwise take the incoming beat directly.
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = s_fire;
            if (s_fire) begin
               out_data_d = s_data;
            end
         end
      end else if (s_fire) begin
         skid_valid_d = 1'b1;
         skid_data_d  = s_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
      end
   end

endmodule

// File: rtl/ether_tx_gate.sv
// ---------------------------------------------------------------------------
// ether_tx_gate
// Link-aware gate between the user TX stream and the MAC TX stream.
// Debounces MAC health into LINK_UP, forwards whole frames only while the
// link is up, flags frames hit by a link fault with TUSER on their TLAST
// beat, and silently drains frames that start while the link is down.
//
// Optional feature macro: ETHER_TX_GATE_STATS_EN adds the FRAMES_SENT,
// FRAMES_DROPPED and FRAMES_ABORTED counter ports.
//
// Ports:
//   CTL_CLK, CTL_RESET            clock, synchronous active-high reset
//   STAT_TX_LOCAL_FAULT, STAT_RX_STATUS, CTL_TX_ENABLE   link health inputs
//   S_AXIS_*                      user TX stream in
//   M_AXIS_TX_*                   MAC TX stream out (TUSER = abort frame)
//   LINK_UP                       debounced link state
//   FRAMES_*                      statistics (macro only)
//
// Link FSM
//   state  | meaning
//   DOWN   | link unhealthy or just lost
//   SETTLE | healthy, counting down to LINK_UP_CYCLES healthy cycles
//   UP     | LINK_UP asserted
// Frame FSM
//   state  | meaning
//   IDLE   | between frames; first beat picks PASS or DROP
//   PASS   | frame forwarded through skid buffer to MAC
//   DROP   | frame discarded, always ready
// ---------------------------------------------------------------------------
module ether_tx_gate
   import ether_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 64,
   parameter int unsigned LINK_UP_CYCLES = LINK_UP_CYCLES_DEFAULT,
   parameter int unsigned CNT_WIDTH      = 32
) (
   input  logic                    CTL_CLK,
   input  logic                    CTL_RESET,
   input  logic                    STAT_TX_LOCAL_FAULT,
   input  logic                    STAT_RX_STATUS,
   input  logic                    CTL_TX_ENABLE,
   input  logic [DATA_WIDTH-1:0]   S_AXIS_TDATA,
   input  logic [DATA_WIDTH/8-1:0] S_AXIS_TKEEP,
   input  logic                    S_AXIS_TLAST,
   input  logic                    S_AXIS_TVALID,
   output logic                    S_AXIS_TREADY,
   output logic [DATA_WIDTH-1:0]   M_AXIS_TX_TDATA,
   output logic [DATA_WIDTH/8-1:0] M_AXIS_TX_TKEEP,
   output logic                    M_AXIS_TX_TLAST,
   output logic                    M_AXIS_TX_TUSER,
   output logic                    M_AXIS_TX_TVALID,
   input  logic                    M_AXIS_TX_TREADY,
   output logic                    LINK_UP
`ifdef ETHER_TX_GATE_STATS_EN
   ,
   output logic [CNT_WIDTH-1:0]    FRAMES_SENT,
   output logic [CNT_WIDTH-1:0]    FRAMES_DROPPED,
   output logic [CNT_WIDTH-1:0]    FRAMES_ABORTED
`endif
);

   localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned PAY_WIDTH  = DATA_WIDTH + KEEP_WIDTH + 2;
   localparam int unsigned SET_WIDTH  = (LINK_UP_CYCLES > 1) ? $clog2(LINK_UP_CYCLES) : 1;
   localparam logic [SET_WIDTH-1:0] SET_LOAD = SET_WIDTH'(LINK_UP_CYCLES - 1);

   // ---------------- link FSM ----------------
   link_state_t          link_q, link_d;
   logic [SET_WIDTH-1:0] settle_cnt_q, settle_cnt_d;
   logic                 healthy;
   logic                 link_up;
   logic                 link_drop;

   assign healthy   = STAT_RX_STATUS & CTL_TX_ENABLE & ~STAT_TX_LOCAL_FAULT;
   assign link_up   = (link_q == UP);
   assign link_drop = link_up & ~healthy;
   assign LINK_UP   = link_up;

   always_comb begin
      link_d       = link_q;
      settle_cnt_d = settle_cnt_q;
      case (link_q)
         DOWN: begin
            if (healthy) begin
               link_d       = SETTLE;
               settle_cnt_d = SET_LOAD;
            end
         end
         SETTLE: begin
            if (!healthy) begin
               link_d       = DOWN;
               settle_cnt_d = '0;
            end else if (settle_cnt_q == '0) begin
               link_d = UP;
            end else begin
               settle_cnt_d = settle_cnt_q - SET_WIDTH'(1);
            end
         end
         UP: begin
            if (!healthy) begin
               link_d = DOWN;
            end
         end
         default: link_d = DOWN;
      endcase
   end

   // ---------------- frame FSM ----------------
   frame_state_t frame_q, frame_d;
   logic         abort_q, abort_d;
   logic         skid_s_ready;
   logic         skid_s_valid;
   logic         s_fire;
   logic         pass_beat;
   logic         user_in;
   logic [PAY_WIDTH-1:0] pay_in;
   logic [PAY_WIDTH-1:0] pay_out;

   // While dropping we sink beats regardless of MAC back-pressure.
   assign S_AXIS_TREADY = ~CTL_RESET & ((frame_q == DROP) | skid_s_ready);
   assign s_fire        = S_AXIS_TVALID & S_AXIS_TREADY;
   assign pass_beat     = (frame_q == PASS) | ((frame_q == IDLE) & link_up);
   assign skid_s_valid  = s_fire & pass_beat;

   // A link drop in the same cycle as the TLAST beat still aborts it.
   assign user_in = S_AXIS_TLAST & (abort_q | link_drop);
   assign pay_in  = {S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TLAST, user_in};

   always_comb begin
      frame_d = frame_q;
      abort_d = abort_q;
      case (frame_q)
         IDLE: begin
            abort_d = 1'b0;
            if (s_fire & ~S_AXIS_TLAST) begin
               if (link_up) begin
                  frame_d = PASS;
                  abort_d = link_drop;
               end else begin
                  frame_d = DROP;
               end
            end
         end
         PASS: begin
            abort_d = abort_q | link_drop;
            if (s_fire & S_AXIS_TLAST) begin
               frame_d = IDLE;
               abort_d = 1'b0;
            end
         end
         DROP: begin
            if (s_fire & S_AXIS_TLAST) begin
               frame_d = IDLE;
            end
         end
         default: frame_d = IDLE;
      endcase
   end

   always_ff @(posedge CTL_CLK) begin
      if (CTL_RESET) begin
         link_q       <= DOWN;
         settle_cnt_q <= '0;
         frame_q      <= IDLE;
         abort_q      <= 1'b0;
      end else begin
         link_q       <= link_d;
         settle_cnt_q <= settle_cnt_d;
         frame_q      <= frame_d;
         abort_q      <= abort_d;
      end
   end

   axis_skid_buf #(
      .WIDTH (PAY_WIDTH)
   ) u_skid (
      .clk     (CTL_CLK),
      .rst     (CTL_RESET),
      .s_data  (pay_in),
      .s_valid (skid_s_valid),
      .s_ready (skid_s_ready),
      .m_data  (pay_out),
      .m_valid (M_AXIS_TX_TVALID),
      .m_ready (M_AXIS_TX_TREADY)
   );

   assign {M_AXIS_TX_TDATA, M_AXIS_TX_TKEEP, M_AXIS_TX_TLAST, M_AXIS_TX_TUSER} = pay_out;

   // ---------------- statistics ----------------
`ifdef ETHER_TX_GATE_STATS_EN
   logic [CNT_WIDTH-1:0] sent_q, sent_d;
   logic [CNT_WIDTH-1:0] dropped_q, dropped_d;
   logic [CNT_WIDTH-1:0] aborted_q, aborted_d;
   logic                 m_last_fire;
   logic                 drop_last;

   assign m_last_fire = M_AXIS_TX_TVALID & M_AXIS_TX_TREADY & M_AXIS_TX_TLAST;
   // Single-beat frames seen while down are dropped straight from IDLE.
   assign drop_last   = s_fire & S_AXIS_TLAST &
                        ((frame_q == DROP) | ((frame_q == IDLE) & ~link_up));

   always_comb begin
      sent_d    = sent_q;
      dropped_d = dropped_q;
      aborted_d = aborted_q;
      if (m_last_fire & ~M_AXIS_TX_TUSER) begin
         sent_d = sent_q + CNT_WIDTH'(1);
      end
      if (m_last_fire & M_AXIS_TX_TUSER) begin
         aborted_d = aborted_q + CNT_WIDTH'(1);
      end
      if (drop_last) begin
         dropped_d = dropped_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge CTL_CLK) begin
      if (CTL_RESET) begin
         sent_q    <= '0;
         dropped_q <= '0;
         aborted_q <= '0;
      end else begin
         sent_q    <= sent_d;
         dropped_q <= dropped_d;
         aborted_q <= aborted_d;
      end
   end

   assign FRAMES_SENT    = sent_q;
   assign FRAMES_DROPPED = dropped_q;
   assign FRAMES_ABORTED = aborted_q;
`else
   logic unused_cnt_width;
   assign unused_cnt_width = ^CNT_WIDTH;
`endif

endmodule

// File: tb/tb_ether_tx_gate.sv
module tb_ether_tx_gate;

   logic        clk;
   logic        CTL_RESET;
   logic        STAT_TX_LOCAL_FAULT;
   logic        STAT_RX_STATUS;
   logic        CTL_TX_ENABLE;
   logic [63:0] S_AXIS_TDATA;
   logic [7:0]  S_AXIS_TKEEP;
   logic        S_AXIS_TLAST;
   logic        S_AXIS_TVALID;
   logic        S_AXIS_TREADY;
   logic [63:0] M_AXIS_TX_TDATA;
   logic [7:0]  M_AXIS_TX_TKEEP;
   logic        M_AXIS_TX_TLAST;
   logic        M_AXIS_TX_TUSER;
   logic        M_AXIS_TX_TVALID;
   logic        M_AXIS_TX_TREADY;
   logic        LINK_UP;
`ifdef ETHER_TX_GATE_STATS_EN
   logic [31:0] FRAMES_SENT;
   logic [31:0] FRAMES_DROPPED;
   logic [31:0] FRAMES_ABORTED;
`endif

   ether_tx_gate #(
      .DATA_WIDTH     (64),
      .LINK_UP_CYCLES (16),
      .CNT_WIDTH      (32)
   ) dut (
      .CTL_CLK             (clk),
      .CTL_RESET           (CTL_RESET),
      .STAT_TX_LOCAL_FAULT (STAT_TX_LOCAL_FAULT),
      .STAT_RX_STATUS      (STAT_RX_STATUS),
      .CTL_TX_ENABLE       (CTL_TX_ENABLE),
      .S_AXIS_TDATA        (S_AXIS_TDATA),
      .S_AXIS_TKEEP        (S_AXIS_TKEEP),
      .S_AXIS_TLAST        (S_AXIS_TLAST),
      .S_AXIS_TVALID       (S_AXIS_TVALID),
      .S_AXIS_TREADY       (S_AXIS_TREADY),
      .M_AXIS_TX_TDATA     (M_AXIS_TX_TDATA),
      .M_AXIS_TX_TKEEP     (M_AXIS_TX_TKEEP),
      .M_AXIS_TX_TLAST     (M_AXIS_TX_TLAST),
      .M_AXIS_TX_TUSER     (M_AXIS_TX_TUSER),
      .M_AXIS_TX_TVALID    (M_AXIS_TX_TVALID),
      .M_AXIS_TX_TREADY    (M_AXIS_TX_TREADY),
      .LINK_UP             (LINK_UP)
`ifdef ETHER_TX_GATE_STATS_EN
      ,
      .FRAMES_SENT         (FRAMES_SENT),
      .FRAMES_DROPPED      (FRAMES_DROPPED),
      .FRAMES_ABORTED      (FRAMES_ABORTED)
`endif
   );

   typedef struct {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      logic        u;
      int          acc;
      bit          lat;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          rdy_mode = 0;
   logic        prev_stall = 1'b0;
   logic [63:0] prev_d;
   logic [7:0]  prev_k;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // MAC ready: 0 = always ready, 1 = random 50%, 2 = stalled
   initial begin
      M_AXIS_TX_TREADY = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0:       M_AXIS_TX_TREADY = 1'b1;
            1:       M_AXIS_TX_TREADY = 1'($urandom_range(0, 1));
            default: M_AXIS_TX_TREADY = 1'b0;
         endcase
      end
   end

   // M-side monitor: pops scoreboard on each handshake, checks stall stability.
   initial forever begin
      @(negedge clk);
      if (!CTL_RESET) begin
         if (prev_stall) begin
            check("m_stall_valid", 64'(M_AXIS_TX_TVALID), 64'd1);
            check("m_stall_data", M_AXIS_TX_TDATA, prev_d);
            check("m_stall_keep", 64'(M_AXIS_TX_TKEEP), 64'(prev_k));
         end
         if (M_AXIS_TX_TVALID && M_AXIS_TX_TREADY) begin
            if (sb.size() == 0) begin
               check("m_unexpected_beat", 64'(M_AXIS_TX_TVALID), 64'd0);
            end else begin
               e = sb.pop_front();
               check("m_tdata", M_AXIS_TX_TDATA, e.d);
               check("m_tkeep", 64'(M_AXIS_TX_TKEEP), 64'(e.k));
               check("m_tlast", 64'(M_AXIS_TX_TLAST), 64'(e.l));
               check("m_tuser", 64'(M_AXIS_TX_TUSER), 64'(e.u));
               if (e.lat) check("m_latency", 64'(cyc), 64'(e.acc));
            end
         end
         prev_stall = M_AXIS_TX_TVALID & ~M_AXIS_TX_TREADY;
         prev_d     = M_AXIS_TX_TDATA;
         prev_k     = M_AXIS_TX_TKEEP;
      end else begin
         prev_stall = 1'b0;
      end
   end

   // Present one beat at posedge+1, wait for acceptance, optionally record it.
   task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                            input bit push, input bit chk_drop, input logic u, input bit lat);
      bit ok;
      ok = 1'b0;
      S_AXIS_TDATA  = d;
      S_AXIS_TKEEP  = k;
      S_AXIS_TLAST  = l;
      S_AXIS_TVALID = 1'b1;
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         if (chk_drop && t == 0) begin
            check("s_tready_drop", 64'(S_AXIS_TREADY), 64'd1);
            check("m_tvalid_drop", 64'(M_AXIS_TX_TVALID), 64'd0);
         end
         if (S_AXIS_TREADY) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("s_accept_timeout", 64'(S_AXIS_TREADY), 64'd1);
      else if (push) sb.push_back('{d, k, l, u, cyc + 1, lat});
      @(posedge clk);
      #1;
      S_AXIS_TVALID = 1'b0;
      S_AXIS_TLAST  = 1'b0;
   endtask

   task automatic send_frame(input int n, input bit drop, input bit abort_last,
                             input bit lat, input int lf_beat);
      for (int i = 0; i < n; i++) begin
         STAT_TX_LOCAL_FAULT = (i == lf_beat);
         send_beat({$urandom, $urandom}, 8'($urandom_range(1, 255)), (i == n - 1),
                   !drop, drop, abort_last && (i == n - 1), lat);
      end
      STAT_TX_LOCAL_FAULT = 1'b0;
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 1000 && sb.size() != 0; t++) begin
         @(posedge clk);
         #2;
      end
      check("sb_drain", 64'(sb.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_up();
      for (int t = 0; t < 100 && !LINK_UP; t++) @(negedge clk);
      check("link_up_wait", 64'(LINK_UP), 64'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      CTL_RESET           = 1'b1;
      STAT_TX_LOCAL_FAULT = 1'b0;
      STAT_RX_STATUS      = 1'b0;
      CTL_TX_ENABLE       = 1'b0;
      S_AXIS_TDATA        = '0;
      S_AXIS_TKEEP        = '0;
      S_AXIS_TLAST        = 1'b0;
      S_AXIS_TVALID       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_s_tready", 64'(S_AXIS_TREADY), 64'd0);
      check("rst_m_tvalid", 64'(M_AXIS_TX_TVALID), 64'd0);
      check("rst_link_up", 64'(LINK_UP), 64'd0);

      // Release reset with healthy link from cycle 0: up 17 cycles later.
      @(posedge clk);
      #1;
      CTL_RESET      = 1'b0;
      STAT_RX_STATUS = 1'b1;
      CTL_TX_ENABLE  = 1'b1;
      @(negedge clk);
      check("s_tready_after_reset", 64'(S_AXIS_TREADY), 64'd1);
      check("link_settle", 64'(LINK_UP), 64'd0);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check("link_settle", 64'(LINK_UP), 64'd0);
      end
      @(negedge clk);
      check("link_rise", 64'(LINK_UP), 64'd1);

      // One unhealthy cycle: LINK_UP falls one cycle later.
      @(posedge clk);
      #1;
      STAT_RX_STATUS = 1'b0;
      @(negedge clk);
      check("link_same_cycle", 64'(LINK_UP), 64'd1);
      @(posedge clk);
      #1;
      STAT_RX_STATUS = 1'b1;
      @(negedge clk);
      check("link_fall", 64'(LINK_UP), 64'd0);

      // Glitch after 10 counted cycles restarts the count.
      repeat (11) @(posedge clk);
      #1;
      STAT_RX_STATUS = 1'b0;
      @(posedge clk);
      #1;
      STAT_RX_STATUS = 1'b1;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         check("link_glitch_hold", 64'(LINK_UP), 64'd0);
      end
      @(negedge clk);
      check("link_glitch_rise", 64'(LINK_UP), 64'd1);
      @(posedge clk);
      #1;

      // 4-beat frame back-to-back with a 1-beat frame.
      send_frame(4, 1'b0, 1'b0, 1'b1, -1);
      send_frame(1, 1'b0, 1'b0, 1'b1, -1);
      wait_drain();
`ifdef ETHER_TX_GATE_STATS_EN
      check("frames_sent_2", 64'(FRAMES_SENT), 64'd2);
`endif

      // Link down: 8-beat frame drained.
      STAT_RX_STATUS = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("link_down", 64'(LINK_UP), 64'd0);
      send_frame(8, 1'b1, 1'b0, 1'b0, -1);
      repeat (2) @(posedge clk);
      #1;
`ifdef ETHER_TX_GATE_STATS_EN
      check("frames_dropped_1", 64'(FRAMES_DROPPED), 64'd1);
`endif
      STAT_RX_STATUS = 1'b1;
      wait_up();

      // Local fault during beat 3: frame completes aborted, next one dropped.
      send_frame(8, 1'b0, 1'b1, 1'b1, 2);
      repeat (3) @(posedge clk);
      #1;
      check("link_after_fault", 64'(LINK_UP), 64'd0);
      send_frame(2, 1'b1, 1'b0, 1'b0, -1);
      wait_drain();
`ifdef ETHER_TX_GATE_STATS_EN
      check("frames_aborted_1", 64'(FRAMES_ABORTED), 64'd1);
      check("frames_dropped_2", 64'(FRAMES_DROPPED), 64'd2);
      check("frames_sent_still_2", 64'(FRAMES_SENT), 64'd2);
`endif
      wait_up();

      // 64-beat frame under random MAC back-pressure.
      rdy_mode = 1;
      send_frame(64, 1'b0, 1'b0, 1'b0, -1);
      wait_drain();
      rdy_mode = 0;
`ifdef ETHER_TX_GATE_STATS_EN
      check("frames_sent_3", 64'(FRAMES_SENT), 64'd3);
`endif

      // Reset mid-frame with the skid buffer full.
      rdy_mode = 2;
      @(posedge clk);
      #1;
      send_beat(64'hA1A1_0000_0000_0001, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_beat(64'hB2B2_0000_0000_0002, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      S_AXIS_TDATA  = 64'hC3C3_0000_0000_0003;
      S_AXIS_TKEEP  = 8'hFF;
      S_AXIS_TLAST  = 1'b0;
      S_AXIS_TVALID = 1'b1;
      @(negedge clk);
      check("s_tready_full", 64'(S_AXIS_TREADY), 64'd0);
      check("m_tvalid_stalled", 64'(M_AXIS_TX_TVALID), 64'd1);
      @(posedge clk);
      #1;
      CTL_RESET = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("midrst_m_tvalid", 64'(M_AXIS_TX_TVALID), 64'd0);
      check("midrst_link_up", 64'(LINK_UP), 64'd0);
      check("midrst_s_tready", 64'(S_AXIS_TREADY), 64'd0);
`ifdef ETHER_TX_GATE_STATS_EN
      check("midrst_sent", 64'(FRAMES_SENT), 64'd0);
      check("midrst_dropped", 64'(FRAMES_DROPPED), 64'd0);
      check("midrst_aborted", 64'(FRAMES_ABORTED), 64'd0);
`endif
      @(posedge clk);
      #1;
      CTL_RESET     = 1'b0;
      S_AXIS_TVALID = 1'b0;
      rdy_mode      = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("m_quiet_after_reset", 64'(M_AXIS_TX_TVALID), 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
